// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: opcodes, states,
// datapath select encodings and the bundled control-word type.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RCOMP   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ILLEGAL = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  typedef struct packed {
    logic   pc_write;
    logic   pc_write_cond;
    logic   i_or_d;
    logic   mem_read;
    logic   mem_write;
    logic   mem_to_reg;
    logic   ir_write;
    logic   reg_dst;
    logic   reg_write;
    logic   alu_src_a;
    srcb_e  alu_src_b;
    aluop_e alu_op;
    pcsrc_e pc_source;
    logic   instr_done;
    logic   illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle: opcode and memory handshake in, mux selects and
// write strobes out. master = control FSM, slave = datapath.
interface mips_multicycle_control_if;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
           illegal_op, state
  );

  modport slave (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
           illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Outputs decode from the
// state register alone, except strobes in memory states, which follow mem_ready.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input logic                          clock,
  input logic                          reset_n,
  mips_multicycle_control_if.master    bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RCOMP;
      S_MEMWB, S_RCOMP, S_BRANCH, S_JUMP, S_ILLEGAL: state_d = S_FETCH;
      // codes 12-15 are unreachable; recover straight into FETCH
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = CTRL_NONE;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.i_or_d     = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = bus.mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RCOMP: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.illegal_op  = ctrl.illegal_op;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multicycle MIPS control FSM: per-cycle expected
// state and input conditions are queued per instruction, then replayed and checked.
module tb_mips_multicycle_control;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic [5:0] op;
  } cyc_t;

  cyc_t sb_q[$];
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned n_done  = 0;
  int unsigned n_ill   = 0;
  int unsigned exp_done = 0;
  int unsigned exp_ill  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,instr_done,illegal_op}
  function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, srca, done, ill;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, srca, done, ill} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd1:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd2:  srcb = 2'b11;
      4'd3:  begin srca = 1; srcb = 2'b10; end
      4'd4:  begin mrd = 1; iord = 1; end
      4'd5:  begin rw = 1; m2r = 1; done = 1; end
      4'd6:  begin iord = 1; mwr = 1; done = mr; end
      4'd7:  begin srca = 1; aop = 2'b10; end
      4'd8:  begin rw = 1; rdst = 1; done = 1; end
      4'd9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      4'd10: begin pcw = 1; pcs = 2'b10; done = 1; end
      4'd11: begin ill = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, srca, srcb, aop, pcs, done, ill};
  endfunction

  function automatic logic [17:0] obs_ctl();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.instr_done, bus.illegal_op};
  endfunction

  function automatic logic [5:0] junk_op();
    return 6'($urandom);
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op);
    cyc_t c;
    c.st = st; c.mr = mr; c.op = op;
    sb_q.push_back(c);
  endtask

  // Queue one instruction: fw/mw = mem_ready-low cycles in FETCH and in MEMRD/MEMWR.
  // Op is only meaningful in DECODE/MEMADR; elsewhere it is scrambled.
  task automatic push_instr(input logic [5:0] op, input int unsigned fw, input int unsigned mw);
    for (int unsigned i = 0; i < fw; i++) push(4'd1, 1'b0, junk_op());
    push(4'd1, 1'b1, junk_op());
    push(4'd2, 1'($urandom), op);
    exp_done++;
    case (op)
      6'h23: begin
        push(4'd3, 1'($urandom), op);
        for (int unsigned i = 0; i < mw; i++) push(4'd4, 1'b0, junk_op());
        push(4'd4, 1'b1, junk_op());
        push(4'd5, 1'($urandom), junk_op());
      end
      6'h2B: begin
        push(4'd3, 1'($urandom), op);
        for (int unsigned i = 0; i < mw; i++) push(4'd6, 1'b0, junk_op());
        push(4'd6, 1'b1, junk_op());
      end
      6'h00: begin
        push(4'd7, 1'($urandom), junk_op());
        push(4'd8, 1'($urandom), junk_op());
      end
      6'h04: push(4'd9,  1'($urandom), junk_op());
      6'h02: push(4'd10, 1'($urandom), junk_op());
      default: begin
        push(4'd11, 1'($urandom), junk_op());
        exp_ill++;
      end
    endcase
  endtask

  // Entered at a falling edge; leaves at the falling edge after the last entry.
  task automatic drain();
    cyc_t c;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      bus.mem_ready = c.mr;
      bus.Op        = c.op;
      #1;
      chk($sformatf("state(exp %0d)", c.st), 32'(bus.state), 32'(c.st));
      chk($sformatf("ctrl@st%0d mr%0d", c.st, c.mr), 32'(obs_ctl()), 32'(exp_ctl(c.st, c.mr)));
      chk("excl", 32'((bus.MemRead & bus.MemWrite) | (bus.RegWrite & bus.PCWrite) |
                      (bus.RegWrite & bus.MemWrite)), 32'd0);
      if (bus.instr_done) n_done++;
      if (bus.illegal_op) n_ill++;
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Op = 6'h00;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset state", 32'(bus.state), 32'd0);
    chk("reset ctrl", 32'(obs_ctl()), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    push(4'd0, 1'b0, junk_op());
    push_instr(6'h23, 0, 0);
    push_instr(6'h2B, 0, 0);
    push_instr(6'h00, 0, 0);
    push_instr(6'h04, 0, 0);
    push_instr(6'h02, 0, 0);
    push_instr(6'h3F, 0, 0);
    push_instr(6'h00, 3, 0);
    push_instr(6'h2B, 1, 3);
    push_instr(6'h23, 2, 2);
    push_instr(6'h08, 1, 0);
    for (int i = 0; i < 12; i++) begin
      logic [5:0] ops [6];
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h11};
      push_instr(ops[$urandom_range(5)], $urandom_range(2), $urandom_range(2));
    end
    drain();
    chk("instr_done count", n_done, exp_done);
    chk("illegal_op count", n_ill, exp_ill);

    // reset while a store is waiting on memory
    push_instr(6'h2B, 0, 0);
    exp_done--;
    void'(sb_q.pop_back());
    push(4'd6, 1'b0, junk_op());
    push(4'd6, 1'b0, junk_op());
    drain();
    bus.mem_ready = 1'b0;
    #1;
    chk("memwr before reset", 32'(bus.MemWrite), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("memwr async drop", 32'(bus.MemWrite), 32'd0);
    chk("state async reset", 32'(bus.state), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    push(4'd0, 1'b1, junk_op());
    push_instr(6'h23, 0, 1);
    push_instr(6'h02, 0, 0);
    drain();
    chk("instr_done total", n_done, exp_done);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
